// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - received-byte bus from the UART front end to the program loader
interface uart_byte_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport master (output data_out, data_valid, frame_error, busy);
  modport slave  (input  data_out, data_valid, frame_error, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver: synchronizer, mid-bit sampling, one-cycle byte strobe
module uart_byte_rx #(
  parameter int DELAY_FRAMES = 234
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rx,
  uart_byte_rx_if.master rx_bus
);

  localparam logic [12:0] BIT_LAST  = 13'(DELAY_FRAMES - 1);
  localparam logic [12:0] HALF_LAST = 13'(DELAY_FRAMES / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 13'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at its mid-point is treated as a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at the stop-bit mid-point gives half a bit of slack for back-to-back frames.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_bus.data_out    = data_q;
  assign rx_bus.data_valid  = valid_q;
  assign rx_bus.frame_error = ferr_q;
  assign rx_bus.busy        = (state_q != IDLE);

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Standalone UART receive front end: synchronizes the raw `uart_rx` pin, detects start bits, samples 8 data bits LSB-first at mid-bit, checks the stop bit and emits one byte per frame as a single-cycle strobe. It sits directly upstream of the program loader, which consumes `data_out`/`data_valid` to assemble instruction words. 8N1 framing only; no parity, no flow control.

## Interface
- `DELAY_FRAMES`, 234: clock cycles per bit (27 MHz / 115200). Legal range 4..8191.
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `uart_rx`  input  1  asynchronous serial line, idle high
- `data_out`  output  8  last received byte; stable until the next good frame
- `data_valid`  output  1  one-cycle pulse, `data_out` is new in that cycle
- `frame_error`  output  1  one-cycle pulse, stop bit sampled low
- `busy`  output  1  high whenever state != IDLE

## Operation
- Input synchronizer: 2 flops; both reset to 1. `rx_s` is the second flop's output. All decisions use `rx_s` only.
- Counter: 13 bits. `HALF = DELAY_FRAMES/2`, integer floor.
- States:
  - IDLE: if `rx_s==0` -> START, counter cleared.
  - START: after HALF cycles, sample `rx_s`. 1 -> IDLE (glitch rejected, no output). 0 -> DATA, bit index 0.
  - DATA: sample every DELAY_FRAMES cycles and shift into `shift[7]`, right-shift, so the first bit lands in bit 0. After the 8th sample -> STOP.
  - STOP: after DELAY_FRAMES cycles, sample `rx_s`.
    - 1: `data_out <= shift`, pulse `data_valid`, -> IDLE.
    - 0: pulse `frame_error`, `data_out` unchanged, -> BREAK.
  - BREAK: wait for `rx_s==1`, then -> IDLE. A line held low never produces repeated errors.
- Return to IDLE occurs at the stop-bit mid-point. This leaves half a bit of margin for back-to-back frames.
- Reset (any state, any cycle):
  - state=IDLE; counter, bit index, shift cleared.
  - `data_out=0`, `data_valid=0`, `frame_error=0`, `busy=0`.
  - Synchronizer flops = 1.
  - A frame in progress is discarded silently.
  - A line that is low when reset is released is treated as a start bit.

## Timing
- Pin-to-`rx_s` latency: 2 cycles.
- Let t0 be the cycle in which IDLE sees `rx_s==0`.
  - Start check at t0+HALF.
  - Data bit i (0..7) sampled at t0+HALF+(i+1)·DELAY_FRAMES.
  - Stop bit sampled at ts = t0+HALF+9·DELAY_FRAMES.
- `data_valid`/`frame_error` are registered: high in cycle ts+1 for exactly 1 cycle. `data_out` is updated in the same cycle as `data_valid`.
- `busy` is high from t0+1 through ts. In BREAK it stays high until `rx_s==1` is seen.
- IDLE is re-entered at ts+1. A falling edge detected in IDLE from cycle ts+1 onward starts a new frame.
- `data_valid` and `frame_error` are never high together. Neither is asserted during or in the cycle after reset.
- Throughput: one byte per 10·DELAY_FRAMES cycles sustained, with no dropped bytes.

## Test plan
Bench uses `DELAY_FRAMES=16` and drives ideal 16-cycle bits unless noted.

- Single frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1):
  - `data_valid` pulses once, 1 cycle wide.
  - `data_out=0xA5`; `frame_error` stays 0.
  - Pulse lands 2+8+9·16+1 cycles after the pin falls.
- Glitch: pin low for 4 cycles, then high for 400 cycles:
  - No `data_valid`, no `frame_error`.
  - `busy` drops back to 0 one cycle after the start check.
- Bad stop bit: frame 0x3C with stop=0, line held low 100 cycles, then high, then a good 0x81:
  - Exactly one `frame_error` pulse; `data_out` stays at its previous value.
  - `busy` stays high until the line rises.
  - Next `data_valid` delivers 0x81.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap:
  - Three `data_valid` pulses, spaced 160 cycles apart, carrying those values in order.
  - Repeat with bit period 15 and with bit period 17: all three bytes still correct.
- Reset mid-frame: assert `reset` 1 cycle during bit 4 of 0xF0, then send 0x12:
  - All outputs read 0 in the cycle after reset.
  - The 0xF0 frame is never reported.
  - 0x12 is received correctly; any truncated-frame residue yields at most a `frame_error`, never a bogus `data_valid`.
